// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared defaults and sel range helper for stream_demux
package stream_demux_pkg;

    localparam int DEMUX_DATA_W_DEF = 8;
    localparam int DEMUX_N_OUT_DEF  = 4;

    function automatic logic sel_in_range(input int sel, input int n_out);
        return (sel >= 0) && (sel < n_out);
    endfunction

endpackage

// File: rtl/stream_demux_out_slot.sv
// rtl/stream_demux_out_slot.sv - one-entry valid/ready output register (demux_out_slot)
module demux_out_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // Load wins over drain so a full slot can refill in the cycle it empties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - registered 1-to-N stream demux; STREAM_DEMUX_RR_EN selects round-robin routing
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter int DATA_W = DEMUX_DATA_W_DEF,
    parameter int N_OUT  = DEMUX_N_OUT_DEF,
    parameter int SEL_W  = $clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic                    drop
);

    logic [SEL_W-1:0] route_sel;
    logic             sel_ok;
    logic             xfer;
    logic [N_OUT-1:0] load;

`ifdef STREAM_DEMUX_RR_EN
    logic [SEL_W-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= (rr_ptr == SEL_W'(N_OUT - 1)) ? '0 : rr_ptr + 1'b1;
        end
    end

    assign route_sel = rr_ptr;
    assign drop      = 1'b0;
`else
    assign route_sel = in_sel;

    // Out-of-range destinations are swallowed and flagged one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop <= 1'b0;
        end else begin
            drop <= xfer & ~sel_ok;
        end
    end
`endif

    assign sel_ok   = sel_in_range(32'(route_sel), N_OUT);
    assign in_ready = sel_ok ? (~out_valid[route_sel] | out_ready[route_sel]) : 1'b1;
    assign xfer     = in_valid & in_ready;

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        assign load[k] = xfer & sel_ok & (route_sel == SEL_W'(k));

        demux_out_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (out_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - randomized model-checked bench for stream_demux (N_OUT=4 and N_OUT=3 instances)
module tb_stream_demux;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic [3:0]  out_ready;
    logic        in_ready, in_ready3;
    logic [31:0] out_data;
    logic [23:0] out_data3;
    logic [3:0]  out_valid;
    logic [2:0]  out_valid3;
    logic        drop, drop3;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    stream_demux #(.DATA_W(8), .N_OUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .drop(drop)
    );

    stream_demux #(.DATA_W(8), .N_OUT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready[2:0]), .drop(drop3)
    );

    wire [3:0]  ov3 = {1'b0, out_valid3};
    wire [31:0] od3 = {8'h00, out_data3};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: each output is a one-deep mailbox; index 0 = 4-output dut, 1 = 3-output dut.
    bit       mfull [2][4];
    bit [7:0] mdata [2][4];
    bit       mdrop [2];
    int       mrr   [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            mdrop[d] = 0;
            mrr[d]   = 0;
            for (int k = 0; k < 4; k++) begin
                mfull[d][k] = 0;
                mdata[d][k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                int n, sel;
                bit rdy, acc;
                logic [3:0]  av;
                logic [31:0] ad;
                n  = (d == 0) ? 4 : 3;
                av = (d == 0) ? out_valid : ov3;
                ad = (d == 0) ? out_data : od3;
                for (int k = 0; k < n; k++) begin
                    chk($sformatf("m%0d_valid%0d", d, k), 32'(av[k]), 32'(mfull[d][k]));
                    if (mfull[d][k])
                        chk($sformatf("m%0d_data%0d", d, k), 32'(ad[k*8 +: 8]), 32'(mdata[d][k]));
                end
                chk($sformatf("m%0d_drop", d), 32'((d == 0) ? drop : drop3), 32'(mdrop[d]));
`ifdef STREAM_DEMUX_RR_EN
                sel = mrr[d];
`else
                sel = int'(in_sel);
`endif
                rdy = (sel >= n) || !mfull[d][sel] || out_ready[sel];
                chk($sformatf("m%0d_in_ready", d), 32'((d == 0) ? in_ready : in_ready3), 32'(rdy));
                if (!rst_n) begin
                    mdrop[d] = 0;
                    mrr[d]   = 0;
                    for (int k = 0; k < 4; k++) mfull[d][k] = 0;
                end else begin
                    acc = in_valid && rdy;
                    for (int k = 0; k < n; k++)
                        if (mfull[d][k] && out_ready[k]) mfull[d][k] = 0;
                    if (acc && sel < n) begin
                        mfull[d][sel] = 1;
                        mdata[d][sel] = in_data;
                    end
`ifdef STREAM_DEMUX_RR_EN
                    mdrop[d] = 0;
`else
                    mdrop[d] = acc && (sel >= n);
`endif
                    if (acc) mrr[d] = (mrr[d] + 1) % n;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] s);
        bit got = 0;
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                got = 1;
                break;
            end
        end
        step();
        in_valid = 1'b0;
        chk("send_accept", 32'(got), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hEE; in_sel = 2'd1; out_ready = 4'b1111;
        step();
        step();
        chk_en = 1;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_drop", 32'(drop), 32'h0);
        step();
        rst_n = 1'b1;
        in_valid = 1'b0;

`ifndef STREAM_DEMUX_RR_EN
        send(8'hEE, 2'd1);
        @(negedge clk);
        chk("first_valid", 32'(out_valid), 32'b0010);
        chk("first_data", 32'(out_data[15:8]), 32'hEE);
        step();

        send(8'hA1, 2'd2);
        @(negedge clk);
        chk("route_a1_valid", 32'(out_valid), 32'b0100);
        chk("route_a1_data", 32'(out_data[23:16]), 32'hA1);
        step();
        send(8'hB2, 2'd0);
        @(negedge clk);
        chk("route_b2_valid", 32'(out_valid), 32'b0001);
        chk("route_b2_data", 32'(out_data[7:0]), 32'hB2);
        step();

        out_ready = 4'b1101;
        send(8'h11, 2'd1);
        @(negedge clk);
        chk("bp_11_valid", 32'(out_valid), 32'b0010);
        step();
        in_data = 8'h22; in_sel = 2'd1; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_22_blocked", 32'(in_ready), 32'h0);
        step();
        in_data = 8'h33; in_sel = 2'd3;
        @(negedge clk);
        chk("bp_33_ready", 32'(in_ready), 32'h1);
        step();
        in_data = 8'h22; in_sel = 2'd1;
        @(negedge clk);
        chk("bp_both_valid", 32'(out_valid), 32'b1010);
        chk("bp_22_still_blocked", 32'(in_ready), 32'h0);
        step();
        out_ready = 4'b1111;
        @(negedge clk);
        chk("bp_release_ready", 32'(in_ready), 32'h1);
        chk("bp_11_held", 32'(out_data[15:8]), 32'h11);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_22_valid", 32'(out_valid), 32'b0010);
        chk("bp_22_data", 32'(out_data[15:8]), 32'h22);
        step();

        for (int i = 0; i < 8; i++) begin
            in_data = 8'(i); in_sel = 2'd0; in_valid = 1'b1;
            @(negedge clk);
            chk("stream_ready", 32'(in_ready), 32'h1);
            if (i > 0) chk("stream_data", 32'(out_data[7:0]), 32'(i - 1));
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last", 32'(out_data[7:0]), 32'h07);
        step();

        send(8'h5A, 2'd3);
        @(negedge clk);
        chk("oor_drop", 32'(drop3), 32'h1);
        chk("oor_valid3", 32'(out_valid3), 32'h0);
        chk("oor_dut4_valid", 32'(out_valid), 32'b1000);
        chk("oor_dut4_drop", 32'(drop), 32'h0);
        step();
        @(negedge clk);
        chk("oor_drop_pulse", 32'(drop3), 32'h0);
        step();

        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) send(8'hC0 + 8'(k), 2'(k));
        @(negedge clk);
        chk("full_valid", 32'(out_valid), 32'b1111);
        step();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; in_sel = 2'd0;
        step();
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'h0);
        chk("midrst_data", out_data, 32'h0);
        step();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 4'b1111;
`else
        begin
            int exp_idx [6] = '{0, 1, 2, 3, 0, 1};
            for (int i = 0; i < 6; i++) begin
                send(8'(i + 1), 2'd0);
                @(negedge clk);
                chk("rr_valid", 32'(out_valid), 32'(4'b0001 << exp_idx[i]));
                chk("rr_data", 32'(out_data[exp_idx[i]*8 +: 8]), 32'(i + 1));
                step();
            end
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        send(8'h77, 2'd2);
        @(negedge clk);
        chk("rr_ptr_reset", 32'(out_valid), 32'b0001);
        step();
`endif

        for (int c = 0; c < 2000; c++) begin
            rst_n     = ($urandom_range(0, 49) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            step();
        end
        rst_n = 1'b1; in_valid = 1'b0;
        step();
        @(negedge clk);
        #1;
        chk_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- Registered 1-to-N stream demultiplexer; the inverse direction of the team's 2:1 combinational mux.
- Routes one valid/ready input stream to one of N_OUT output streams, chosen by in_sel.
- Each output has a one-entry register, so a stalled output does not block transfers to other outputs.
- Sits between a single producer and several independent consumers.

Parameters:
DATA_W, 8, payload width in bits
N_OUT, 4, number of output streams (2..16)
SEL_W, $clog2(N_OUT), width of in_sel (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_data  input  DATA_W  input payload
in_sel  input  SEL_W  destination index; qualified by in_valid
in_valid  input  1  input payload/sel valid
in_ready  output  1  block accepts input this cycle
out_data  output  N_OUT*DATA_W  output payloads; slot k = bits [k*DATA_W +: DATA_W]
out_valid  output  N_OUT  per-output valid
out_ready  input  N_OUT  per-output ready from consumers
drop  output  1  one-cycle pulse: an accepted input had an out-of-range in_sel

Behaviour:
- Reset (rst_n=0 at clk edge): out_valid=0, out_data=0, drop=0; any held payloads are discarded.
- Reset has priority over every other event in the same cycle.
- Input transfer: occurs when in_valid & in_ready.
- Output k transfer: occurs when out_valid[k] & out_ready[k].
- in_ready is combinational from in_sel, out_valid and out_ready:
  - 1 if in_sel >= N_OUT;
  - otherwise ~out_valid[in_sel] | out_ready[in_sel].
- Producer rule: in_valid must not depend on in_ready.
- Slot k update per cycle:
  - Load (input transfer with in_sel==k): next out_valid[k]=1, out_data slot k = in_data.
  - Drain only (output transfer, no load): out_valid[k] cleared.
  - Load and drain in the same cycle: slot stays valid with the new data. Sustained throughput is 1 word/cycle per output.
  - Otherwise: hold. out_data slot k must stay stable while out_valid[k] & ~out_ready[k].
- Latency: data appears on out_data one clock after the input transfer.
- Other outputs are unaffected; several slots may drain in the same cycle.
- Out-of-range sel (only possible when N_OUT is not a power of 2): input is accepted and discarded; drop=1 in the following cycle; no slot changes.
- drop is registered; otherwise 0.
- out_ready[k] is ignored while out_valid[k]=0.
- No internal FSM beyond the per-slot valid bit.

Optional Feature:
- Macro: STREAM_DEMUX_RR_EN.
- Defined:
  - in_sel is ignored; routing uses an internal pointer rr_ptr (SEL_W bits).
  - rr_ptr resets to 0 and advances by 1 on each input transfer, wrapping N_OUT-1 -> 0.
  - in_ready uses rr_ptr in place of in_sel.
  - drop is tied to 0.
- Not defined: in_sel routing as above; no rr_ptr logic exists.

Decomposition:
- Package stream_demux_pkg holds:
  - DEMUX_DATA_W_DEF=8 and DEMUX_N_OUT_DEF=4;
  - a sel-in-range check function.
- Sub-module demux_out_slot: one-entry valid/ready register with load, drain and hold behaviour, parameterised by DATA_W.
- demux_out_slot is instantiated N_OUT times via generate. Top level holds the in_ready mux, drop register and optional rr_ptr.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0000, out_data=0, drop=0; release; first transfer lands normally.
2. Routing: all out_ready=1; send 0xA1 sel=2, then 0xB2 sel=0 -> out_valid[2]=1 with 0xA1 next cycle; then out_valid[0]=1 with 0xB2; in_ready stays 1.
3. Back-pressure isolation:
   - Setup: out_ready[1]=0; send 0x11 sel=1, then 0x22 sel=1, then 0x33 sel=3.
   - Expect: in_ready=0 while presenting 0x22; 0x33 still accepted once presented.
   - Release: raise out_ready[1] -> 0x11 delivered, 0x22 accepted the same cycle and delivered the next cycle.
4. Streaming: out_ready[0]=1, 8 back-to-back words 0x00..0x07 to sel=0 -> in_ready=1 every cycle; out_data slot 0 shows 0x00..0x07 on consecutive cycles.
5. N_OUT=3 build: send 0x5A sel=3 -> accepted, drop=1 one cycle later, out_valid unchanged.
6. STREAM_DEMUX_RR_EN build: send 0x01..0x06 (in_sel=0) -> delivered to outputs 0,1,2,3,0,1.
7. Mid-operation reset: assert rst_n=0 with all slots full -> all out_valid=0 next cycle; rr_ptr=0 in the RR build.
